// File: rtl/dlsc_demosaic_vng6_seq_if.sv
// dlsc_demosaic_vng6_seq_if: frame control plus pixel-in / result-out handshakes of the VNG6 sequencer.
interface dlsc_demosaic_vng6_seq_if #(
   parameter int XB = 12,
   parameter int YB = 12
);
   logic          start;
   logic [XB-1:0] cfg_width;
   logic [YB-1:0] cfg_height;
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   modport master(output start, cfg_width, cfg_height, in_valid, out_ready, input in_ready, out_valid);
   modport slave(input start, cfg_width, cfg_height, in_valid, out_ready, output in_ready, out_valid);
endinterface

// File: rtl/dlsc_demosaic_vng6_seq.sv
// dlsc_demosaic_vng6_seq: 12-step slot sequencer for the VNG6 demosaic datapath (step index, result tokens, frame counters).
// Optional stall counter enabled by defining DLSC_DEMOSAIC_VNG6_SEQ_STALL_COUNT_EN.
module dlsc_demosaic_vng6_seq #(
   parameter int XB   = 12,
   parameter int YB   = 12,
   parameter int PIPE = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   dlsc_demosaic_vng6_seq_if.slave        bus,
   output logic [3:0]                     st,
   output logic                           clk_en,
   output logic [XB-1:0]                  x,
   output logic [YB-1:0]                  y,
   output logic                           busy,
   output logic                           frame_done,
   output logic [15:0]                    stall_count
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t          state_q, state_d;
   logic [3:0]      st_q, st_d;
   logic [XB-1:0]   x_q, x_d, w_q, w_d;
   logic [YB-1:0]   y_q, y_d, h_q, h_d;
   logic            slot_real_q, slot_real_d;
   logic            out_valid_q, out_valid_d;
   logic            frame_done_q, frame_done_d;
   logic [PIPE-1:0] tok_q, tok_d;
   logic [PIPE:0]   tok_sh;
   logic            stall, accept, last_px, row_end;

   assign stall        = out_valid_q && !bus.out_ready;
   assign clk_en       = state_q != IDLE && !stall && (st_q != 4'd0 || state_q == FLUSH || bus.in_valid);
   assign bus.in_ready = state_q == RUN && st_q == 4'd0 && !stall;
   assign accept       = bus.in_valid && bus.in_ready;
   assign row_end      = x_q == w_q;
   assign last_px      = accept && row_end && y_q == h_q;
   // The top bit of tok_sh is the token leaving the pipe on this clk_en.
   assign tok_sh       = {tok_q, st_q == 4'd11 && slot_real_q};

   always_comb begin
      state_d      = state_q;
      w_d          = w_q;
      h_d          = h_q;
      x_d          = accept ? (row_end ? '0 : x_q + XB'(1)) : x_q;
      y_d          = accept && row_end ? y_q + YB'(1) : y_q;
      st_d         = clk_en ? (st_q == 4'd11 ? 4'd0 : st_q + 4'd1) : st_q;
      slot_real_d  = accept ? 1'b1 : (clk_en && st_q == 4'd11) ? 1'b0 : slot_real_q;
      tok_d        = clk_en ? tok_sh[PIPE-1:0] : tok_q;
      out_valid_d  = (clk_en && tok_sh[PIPE]) ? 1'b1 : bus.out_ready ? 1'b0 : out_valid_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = RUN;
            w_d     = bus.cfg_width;
            h_d     = bus.cfg_height;
            x_d     = '0;
            y_d     = '0;
         end
         RUN: if (last_px) state_d = FLUSH;
         FLUSH: if (!slot_real_q && tok_q == '0 && !out_valid_q) begin
            state_d      = IDLE;
            st_d         = 4'd0;
            frame_done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q      <= IDLE;
         st_q         <= 4'd0;
         x_q          <= '0;
         y_q          <= '0;
         w_q          <= '0;
         h_q          <= '0;
         slot_real_q  <= 1'b0;
         tok_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         st_q         <= st_d;
         x_q          <= x_d;
         y_q          <= y_d;
         w_q          <= w_d;
         h_q          <= h_d;
         slot_real_q  <= slot_real_d;
         tok_q        <= tok_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end

`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STALL_COUNT_EN
   logic [15:0] stall_count_q, stall_count_d;
   always_comb
      stall_count_d = (state_q == IDLE && bus.start) ? 16'd0 :
                      (state_q != IDLE && !clk_en && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) stall_count_q <= 16'd0;
      else stall_count_q <= stall_count_d;
   assign stall_count = stall_count_q;
`else
   assign stall_count = 16'd0;
`endif

   assign st            = st_q;
   assign x             = x_q;
   assign y             = y_q;
   assign busy          = state_q != IDLE;
   assign frame_done    = frame_done_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_dlsc_demosaic_vng6_seq.sv
// tb_dlsc_demosaic_vng6_seq: frame-level scoreboard for the VNG6 sequencer, table-driven random frames plus corner sequences.
module tb_dlsc_demosaic_vng6_seq;
   localparam int XB = 12, YB = 12, P0 = 8, P1 = 20;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   dlsc_demosaic_vng6_seq_if #(.XB(XB), .YB(YB)) b0 ();
   dlsc_demosaic_vng6_seq_if #(.XB(XB), .YB(YB)) b1 ();
   logic [3:0] st0, st1;
   logic ce0, ce1, busy0, busy1, fd0, fd1;
   logic [XB-1:0] x0, x1;
   logic [YB-1:0] y0, y1;
   logic [15:0] sc0, sc1;

   dlsc_demosaic_vng6_seq #(.XB(XB), .YB(YB), .PIPE(P0)) u0 (
      .clk(clk), .rst(rst), .bus(b0), .st(st0), .clk_en(ce0), .x(x0), .y(y0),
      .busy(busy0), .frame_done(fd0), .stall_count(sc0));
   dlsc_demosaic_vng6_seq #(.XB(XB), .YB(YB), .PIPE(P1)) u1 (
      .clk(clk), .rst(rst), .bus(b1), .st(st1), .clk_en(ce1), .x(x1), .y(y1),
      .busy(busy1), .frame_done(fd1), .stall_count(sc1));

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: frame geometry, slot position and outstanding results, derived from accepts and handshakes.
   int cyc = 0, cen = 0, m_st = 0, m_w = 0, m_h = 0, m_acc = 0, m_total = 0, m_end = -1, m_last_acc = 0;
   int res_cnt = 0, fd_cnt = 0, f_acc0 = 0, f_res0 = 0, f_fd = 0;
   bit m_busy = 0, m_pend = 0, prev_ov = 0, prev_or = 0;
   int lat_q[$];
   logic [15:0] m_sc = 16'd0;

   always @(negedge clk) begin
      bit flush, e_stall, e_ce, e_ir;
      cyc++;
      if (rst) begin
         chk("rst_busy", busy0, 0); chk("rst_st", st0, 0); chk("rst_xy", {x0, y0}, 0);
         chk("rst_out_valid", b0.out_valid, 0); chk("rst_frame_done", fd0, 0);
         chk("rst_in_ready", b0.in_ready, 0); chk("rst_stall_count", sc0, 0);
         m_busy = 0; m_st = 0; m_pend = 0; m_end = -1; m_sc = 0; prev_ov = 0; res_cnt = 0; m_acc = 0;
         lat_q.delete();
      end else begin
         if (cyc == m_end) begin m_busy = 0; m_st = 0; end
         flush   = m_busy && m_acc == m_total;
         e_stall = b0.out_valid && !b0.out_ready;
         e_ce    = m_busy && !e_stall && (m_st != 0 || flush || b0.in_valid);
         e_ir    = m_busy && !flush && m_st == 0 && !e_stall;
         chk("busy", busy0, m_busy);
         chk("st", st0, m_st);
         chk("clk_en", ce0, e_ce);
         chk("in_ready", b0.in_ready, e_ir);
         chk("frame_done", fd0, cyc == m_end);
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STALL_COUNT_EN
         chk("stall_count", sc0, m_sc);
`else
         chk("stall_count", sc0, 0);
`endif
         if (b0.in_valid && e_ir) begin
            chk("x", x0, m_acc % (m_w + 1));
            chk("y", y0, m_acc / (m_w + 1));
            if (m_acc > 0) chk("accept_gap_ge_12", cyc - m_last_acc >= 12, 1);
            else f_acc0 = cyc;
            m_last_acc = cyc; m_acc++; m_pend = 1;
         end
         if (m_st == 11 && e_ce && m_pend) begin lat_q.push_back(cen); m_pend = 0; end
         if (b0.out_valid && (!prev_ov || prev_or)) begin
            chk("result_pending", lat_q.size() > 0, 1);
            if (lat_q.size() > 0) chk("result_latency", cen - lat_q.pop_front(), P0 + 1);
            if (res_cnt == 0) f_res0 = cyc;
            res_cnt++;
         end
         if (b0.out_valid && b0.out_ready && res_cnt == m_total && m_acc == m_total && lat_q.size() == 0 && !m_pend)
            m_end = cyc + 2;
         if (fd0) begin fd_cnt++; f_fd = cyc; end
         if (!m_busy && b0.start) m_sc = 0;
         else if (m_busy && !e_ce && m_sc != 16'hFFFF) m_sc++;
         if (e_ce) begin m_st = (m_st == 11) ? 0 : m_st + 1; cen++; end
         if (!m_busy && b0.start) begin
            m_busy = 1; m_w = int'(b0.cfg_width); m_h = int'(b0.cfg_height);
            m_acc = 0; m_total = (m_w + 1) * (m_h + 1); res_cnt = 0; m_pend = 0; m_end = -1;
         end
         prev_ov = b0.out_valid; prev_or = b0.out_ready;
      end
   end

   task automatic start0(input int w, input int h);
      b0.cfg_width = XB'(w); b0.cfg_height = YB'(h); b0.start = 1'b1;
      tick();
      b0.start = 1'b0;
   endtask

   task automatic wait_fd(input int t, input int budget);
      int n = 0;
      while (fd_cnt == t && n < budget) begin tick(); n++; end
      chk("frame_done_seen", fd_cnt - t, 1);
   endtask

   task automatic run_frame(input int w, input int h, input int pv, input int pr);
      int t = fd_cnt, n = 0;
      start0(w, h);
      while (fd_cnt == t && n < 6000) begin
         b0.in_valid  = $urandom_range(99) < pv;
         b0.out_ready = $urandom_range(99) < pr;
         tick(); n++;
      end
      chk("frame_done_seen", fd_cnt - t, 1);
      b0.in_valid = 1'b0; b0.out_ready = 1'b1;
   endtask

   typedef struct {int w, h, pv, pr, acc;} vec_t;
   vec_t tv[6];

   initial begin
      int t, acc1, ov1, wr1, a1c, r1c;
      bit fdseen;
      tv[0] = '{3, 1, 100, 100, 8};
      tv[1] = '{0, 0, 100, 100, 1};
      tv[2] = '{4, 2, 60, 70, 15};
      tv[3] = '{1, 3, 30, 90, 8};
      tv[4] = '{7, 0, 80, 40, 8};
      tv[5] = '{2, 2, 50, 50, 9};
      {b0.start, b0.in_valid, b0.cfg_width, b0.cfg_height} = '0; b0.out_ready = 1'b1;
      {b1.start, b1.in_valid, b1.cfg_width, b1.cfg_height} = '0; b1.out_ready = 1'b1;
      #1 rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);

      foreach (tv[i]) begin
         run_frame(tv[i].w, tv[i].h, tv[i].pv, tv[i].pr);
         chk("tv_accepts", m_acc, tv[i].acc);
         chk("tv_results", res_cnt, tv[i].acc);
         tick(3);
      end

      // Steady stream: exact timing of first result and frame end.
      run_frame(3, 1, 100, 100);
      chk("steady_first_result", f_res0 - f_acc0, 12 + P0);
      chk("steady_frame_length", f_fd - f_acc0, 98 + P0);
      tick(2);

      // Backpressure from the first result onward.
      t = fd_cnt;
      b0.in_valid = 1'b1; b0.out_ready = 1'b1;
      start0(3, 1);
      for (int i = 0; i < 100 && !b0.out_valid; i++) tick();
      chk("bp_result_seen", b0.out_valid, 1);
      b0.out_ready = 1'b0;
      #1;
      for (int i = 0; i < 30; i++) begin
         chk("bp_clk_en", ce0, 0);
         chk("bp_st_frozen", st0, (12 + P0) % 12);
         chk("bp_in_ready", b0.in_ready, 0);
         tick();
      end
      b0.out_ready = 1'b1;
      wait_fd(t, 2000);
      chk("bp_results", res_cnt, 8);
      b0.in_valid = 1'b0;
      tick(2);

      // Input starvation at st==0.
      t = fd_cnt;
      start0(3, 1);
      for (int i = 0; i < 20; i++) begin
         chk("starve_clk_en", ce0, 0);
         chk("starve_st", st0, 0);
         tick();
      end
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STALL_COUNT_EN
      chk("starve_stall_count", sc0, 20);
`else
      chk("starve_stall_count", sc0, 0);
`endif
      b0.in_valid = 1'b1;
      wait_fd(t, 2000);
      b0.in_valid = 1'b0;
      tick(2);

      // Start pulse while busy must not disturb the frame.
      t = fd_cnt;
      b0.in_valid = 1'b1;
      start0(3, 1);
      tick(30);
      b0.cfg_width = XB'(7); b0.cfg_height = YB'(7); b0.start = 1'b1;
      tick();
      b0.start = 1'b0;
      chk("busy_start_x", x0, 3);
      chk("busy_start_y", y0, 0);
      chk("busy_start_busy", busy0, 1);
      wait_fd(t, 2000);
      chk("busy_start_accepts", m_acc, 8);
      b0.in_valid = 1'b0;
      tick(2);

      // Abort by reset after five pixels, then a clean frame.
      t = fd_cnt;
      b0.in_valid = 1'b1;
      start0(3, 1);
      for (int i = 0; i < 200 && m_acc < 5; i++) tick();
      chk("abort_reached_px5", m_acc, 5);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy0, 0);
      chk("abort_st", st0, 0);
      chk("abort_xy", {x0, y0}, 0);
      chk("abort_out_valid", b0.out_valid, 0);
      chk("abort_clk_en", ce0, 0);
      tick(2);
      rst = 1'b0;
      b0.in_valid = 1'b0;
      tick(40);
      chk("abort_no_frame_done", fd_cnt, t);
      run_frame(3, 1, 100, 100);
      chk("abort_clean_results", res_cnt, 8);
      tick(2);

      // 1x1 frame through the deep pipe.
      b1.in_valid = 1'b1; b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      {acc1, ov1, wr1, a1c, r1c, fdseen} = '0;
      for (int i = 0; i < 200 && !fdseen; i++) begin
         if (b1.in_valid && b1.in_ready) begin acc1++; a1c = i; end
         if (b1.out_valid) begin ov1++; r1c = i; end
         if (st1 == 4'd11 && ce1) wr1++;
         if (fd1) fdseen = 1;
         tick();
      end
      chk("px1_accepts", acc1, 1);
      chk("px1_results", ov1, 1);
      chk("px1_slot_wraps", wr1, 2);
      chk("px1_latency", r1c - a1c, 12 + P1);
      chk("px1_frame_done", fdseen, 1);
      chk("px1_idle_st", st1, 0);
      chk("px1_idle_busy", busy1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
